// File: rtl/y_fetch_queue.sv
// y_fetch_queue: instruction fetch unit with a small in-order instruction queue.
// Issues at most one memory request at a time and queues {instruction, pc}
// pairs for the consumer. A redirect flushes the queue and retargets the fetch
// PC. Any response already in flight is dropped so that no pre-redirect
// instruction ever reaches the consumer.
module y_fetch_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int STEP  = 4
) (
    input  logic                       clk,
    input  logic                       INT_n,
    input  logic [WIDTH-1:0]           entryPoint,
    output logic                       imem_req,
    output logic [WIDTH-1:0]           imem_addr,
    input  logic                       imem_gnt,
    input  logic                       imem_rvalid,
    input  logic [WIDTH-1:0]           imem_rdata,
    input  logic                       redirect,
    input  logic [WIDTH-1:0]           redirect_pc,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_ins,
    output logic [WIDTH-1:0]           out_pc,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0]    FULL   = CW'(DEPTH);
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    typedef enum logic [1:0] {BOOT, REQ, WAIT, DRAIN} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] fetch_pc, fetch_pc_nxt;
    logic [WIDTH-1:0] req_pc;
    logic [AW-1:0]    head, tail;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] ins_q [DEPTH];
    logic [WIDTH-1:0] pc_q  [DEPTH];

    logic push, pop, flush, req_fire;

    // The PC register is the fetch address, so it stays stable while a request waits for grant.
    assign imem_req  = (state == REQ) && (cnt < FULL);
    assign imem_addr = fetch_pc;
    assign req_fire  = imem_req && imem_gnt;

    assign out_valid = (cnt != '0);
    assign out_ins   = out_valid ? ins_q[head] : '0;
    assign out_pc    = out_valid ? pc_q[head]  : '0;
    assign count     = cnt;

    // A redirect wins over both ends of the queue.
    assign pop = out_valid && out_ready && !flush;

    // Next-state, next fetch PC, push and flush decisions.
    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        push         = 1'b0;
        flush        = 1'b0;
        case (state)
            BOOT: begin
                state_nxt    = REQ;
                fetch_pc_nxt = entryPoint;
            end
            REQ: begin
                if (redirect) begin
                    flush        = 1'b1;
                    fetch_pc_nxt = redirect_pc;
                    // A request granted in this cycle is now stale and must be drained.
                    state_nxt    = req_fire ? DRAIN : REQ;
                end else if (req_fire) begin
                    fetch_pc_nxt = fetch_pc + STEP_W;
                    state_nxt    = WAIT;
                end
            end
            WAIT: begin
                if (redirect) begin
                    flush        = 1'b1;
                    fetch_pc_nxt = redirect_pc;
                    // If the stale response is arriving right now it is dropped here,
                    // because no further response will come for DRAIN to absorb.
                    state_nxt    = imem_rvalid ? REQ : DRAIN;
                end else if (imem_rvalid) begin
                    push      = 1'b1;
                    state_nxt = REQ;
                end
            end
            DRAIN: begin
                if (redirect) begin
                    flush        = 1'b1;
                    fetch_pc_nxt = redirect_pc;
                end
                if (imem_rvalid) begin
                    state_nxt = REQ;
                end
            end
            default: state_nxt = BOOT;
        endcase
    end

    // FSM state, fetch PC and the PC of the outstanding request.
    always_ff @(posedge clk or negedge INT_n) begin
        if (!INT_n) begin
            state    <= BOOT;
            fetch_pc <= '0;
            req_pc   <= '0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            if (req_fire) begin
                req_pc <= fetch_pc;
            end
        end
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clk or negedge INT_n) begin
        if (!INT_n) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else if (flush) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Queue storage: write the returned instruction and its PC at the tail.
    always_ff @(posedge clk or negedge INT_n) begin
        if (!INT_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ins_q[i] <= '0;
                pc_q[i]  <= '0;
            end
        end else if (push) begin
            ins_q[tail] <= imem_rdata;
            pc_q[tail]  <= req_pc;
        end
    end

endmodule
